// File: rtl/vec_lane_exec.sv
// -----------------------------------------------------------------------------
// vec_lane_exec
//   Iterative vector execute stage that sits directly behind the register bank.
//   One accepted operation latches a V-bit operand pair. The unit then works
//   through the operands LPC lanes (one chunk) per cycle over K = V/(EW*LPC)
//   cycles. It finishes with a single-cycle write-back that feeds the bank's
//   write port. Each EW-bit lane is computed on its own, so no carry or borrow
//   crosses a lane boundary.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous, active-high reset
//   in_valid  in   1   operation request
//   in_ready  out  1   high only while idle (combinational from state)
//   op        in   3   lane opcode: ADD SUB ADDS SUBS MULL AND OR XOR
//   bcast     in   1   use opb lane 0 as the B operand of every lane
//   wa_in     in   M   destination register address
//   opa       in   V   operand A
//   opb       in   V   operand B
//   we_out    out  1   write-back strobe, one cycle per operation
//   wa_out    out  M   write-back address (holds between operations)
//   wd_out    out  V   write-back data (holds between operations)
//   busy      out  1   high whenever the unit is not idle
// -----------------------------------------------------------------------------
module vec_lane_exec #(
    parameter int V   = 128,
    parameter int M   = 4,
    parameter int EW  = 8,
    parameter int LPC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         bcast,
    input  logic [M-1:0] wa_in,
    input  logic [V-1:0] opa,
    input  logic [V-1:0] opb,
    output logic         we_out,
    output logic [M-1:0] wa_out,
    output logic [V-1:0] wd_out,
    output logic         busy
);

    localparam int CW    = EW * LPC;                  // bits handled per cycle
    localparam int K     = V / CW;                    // chunk cycles per operation
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic               bcast_q;
    logic [M-1:0]       wa_q;
    logic [V-1:0]       opa_q;
    logic [V-1:0]       opb_q;
    logic [V-1:0]       res_q;

    logic [CW-1:0]      chunk_a;
    logic [CW-1:0]      chunk_b;
    logic [CW-1:0]      chunk_r;
    logic [V-1:0]       res_next;

    // Unsigned saturating add: clamp to all-ones when the carry out is set.
    function automatic logic [EW-1:0] sat_add(input logic [EW-1:0] a,
                                              input logic [EW-1:0] b);
        logic [EW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[EW] ? {EW{1'b1}} : sum[EW-1:0];
    endfunction

    // Unsigned saturating subtract: clamp to zero on underflow.
    function automatic logic [EW-1:0] sat_sub(input logic [EW-1:0] a,
                                              input logic [EW-1:0] b);
        return (a < b) ? {EW{1'b0}} : (a - b);
    endfunction

    // Result for one lane.
    function automatic logic [EW-1:0] lane_op(input logic [2:0]    f,
                                              input logic [EW-1:0] a,
                                              input logic [EW-1:0] b);
        logic [2*EW-1:0] prod;
        logic [EW-1:0]   r;
        prod = {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
        case (f)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = sat_add(a, b);
            3'b011:  r = sat_sub(a, b);
            3'b100:  r = prod[EW-1:0];
            3'b101:  r = a & b;
            3'b110:  r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Select the active chunk, run its lanes, and merge the result into the
    // accumulated vector. Chunk selection is a compare against every chunk
    // index, which avoids a variable part-select on the wide operands.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int k = 0; k < K; k++) begin
            if (cnt == CNT_W'(k)) begin
                chunk_a = opa_q[k*CW +: CW];
                chunk_b = opb_q[k*CW +: CW];
            end
        end

        chunk_r = '0;
        for (int l = 0; l < LPC; l++) begin
            chunk_r[l*EW +: EW] = lane_op(op_q, chunk_a[l*EW +: EW],
                                          bcast_q ? opb_q[EW-1:0] : chunk_b[l*EW +: EW]);
        end

        res_next = res_q;
        for (int k = 0; k < K; k++) begin
            if (cnt == CNT_W'(k)) begin
                res_next[k*CW +: CW] = chunk_r;
            end
        end
    end

    // Control state and the outputs are reset. The latched operands and the
    // result accumulator are loaded on every accept, so they carry no reset.
    // The last chunk goes straight to wd_out through res_next. This lets the
    // write-back pulse start on the same edge that finishes the final chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            we_out <= 1'b0;
            wa_out <= '0;
            wd_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    we_out <= 1'b0;
                    if (in_valid) begin
                        op_q    <= op;
                        bcast_q <= bcast;
                        wa_q    <= wa_in;
                        opa_q   <= opa;
                        opb_q   <= opb;
                        res_q   <= '0;
                        cnt     <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    res_q <= res_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(K - 1)) begin
                        state  <= S_DONE;
                        we_out <= 1'b1;
                        wa_out <= wa_q;
                        wd_out <= res_next;
                    end
                end
                S_DONE: begin
                    we_out <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    we_out <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_lane_exec.sv
// -----------------------------------------------------------------------------
// tb_vec_lane_exec
//   Self-checking bench for vec_lane_exec. A lane-by-lane reference model
//   written with integer arithmetic supplies the expected write-back data.
//   Directed cases cover wrap, saturation, broadcast multiply, reset while
//   busy and a scalar destination. Random operations are checked against the
//   model. In the final phase in_valid is held high continuously.
// -----------------------------------------------------------------------------
module tb_vec_lane_exec;

    localparam int V = 128;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         bcast;
    logic [M-1:0] wa_in;
    logic [V-1:0] opa;
    logic [V-1:0] opb;
    logic         we_out;
    logic [M-1:0] wa_out;
    logic [V-1:0] wd_out;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    vec_lane_exec dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .bcast    (bcast),
        .wa_in    (wa_in),
        .opa      (opa),
        .opb      (opb),
        .we_out   (we_out),
        .wa_out   (wa_out),
        .wd_out   (wd_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [V-1:0] obs,
                             input logic [V-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: 16 independent unsigned byte lanes, plain integer math.
    function automatic logic [V-1:0] model(input logic [2:0] f, input logic bc,
                                           input logic [V-1:0] a,
                                           input logic [V-1:0] b);
        logic [V-1:0] r;
        int x, y, z;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            x = int'(a[i*8 +: 8]);
            y = bc ? int'(b[7:0]) : int'(b[i*8 +: 8]);
            case (f)
                3'd0:    z = (x + y) % 256;
                3'd1:    z = (x - y + 256) % 256;
                3'd2:    z = (x + y > 255) ? 255 : x + y;
                3'd3:    z = (x < y) ? 0 : x - y;
                3'd4:    z = (x * y) % 256;
                3'd5:    z = x & y;
                3'd6:    z = x | y;
                default: z = x ^ y;
            endcase
            r[i*8 +: 8] = 8'(z);
        end
        return r;
    endfunction

    function automatic logic [V-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one op from idle. Then check its latency, address and data, and
    // check that the outputs hold afterwards.
    task automatic run_op(input string tag, input logic [2:0] f, input logic bc,
                          input logic [M-1:0] wa, input logic [V-1:0] a,
                          input logic [V-1:0] b, input logic [V-1:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, ".ready"}, in_ready, 1);
        op = f; bcast = bc; wa_in = wa; opa = a; opb = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opa = rnd128();
        opb = rnd128();
        op = 3'($urandom);
        wa_in = 4'($urandom);
        check_val({tag, ".busy"}, busy, 1);
        check_val({tag, ".ready_low"}, in_ready, 0);
        n = 0;
        while (!we_out && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, ".latency"}, n, 4);
        check_val({tag, ".we"}, we_out, 1);
        check_val({tag, ".wa"}, wa_out, wa);
        check_val({tag, ".wd"}, wd_out, exp);
        @(posedge clk); #1;
        check_val({tag, ".we_drop"}, we_out, 0);
        check_val({tag, ".wd_hold"}, wd_out, exp);
        check_val({tag, ".wa_hold"}, wa_out, wa);
    endtask

    initial begin
        logic [V-1:0] a, b, e;
        logic [2:0]   f;
        logic         bc;
        logic [M-1:0] wa;
        int           last_acc;
        int           pulses;
        logic [V-1:0] pend_wd;
        logic [M-1:0] pend_wa;
        logic         exp_ready;
        logic         exp_we;

        rst = 1'b1; in_valid = 1'b0; op = '0; bcast = 1'b0;
        wa_in = '0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.we", we_out, 0);
        check_val("rst.wa", wa_out, 0);
        check_val("rst.wd", wd_out, 0);
        check_val("rst.busy", busy, 0);
        check_val("rst.ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Every lane wraps to zero.
        run_op("t1_add_wrap", 3'd0, 1'b0, 4'hC, {16{8'hFF}}, {16{8'h01}}, '0);

        // Saturation versus wrap.
        run_op("t2_adds", 3'd2, 1'b0, 4'h5, {16{8'hF0}}, {16{8'h20}}, {16{8'hFF}});
        run_op("t2_subs", 3'd3, 1'b0, 4'h6, {16{8'h10}}, {16{8'h20}}, '0);
        run_op("t2_sub",  3'd1, 1'b0, 4'h7, {16{8'h10}}, {16{8'h20}}, {16{8'hF0}});

        // Broadcast multiply: lane i = 3*i.
        for (int i = 0; i < 16; i++) begin
            a[i*8 +: 8] = 8'(i);
            e[i*8 +: 8] = 8'(3 * i);
        end
        run_op("t3_mull_bc", 3'd4, 1'b1, 4'hE, a, 128'h0000_0003, e);

        // Scalar destination, XOR of equal operands, AND/OR spot values.
        run_op("t6_xor", 3'd7, 1'b0, 4'h3, {16{8'hA5}}, {16{8'hA5}}, '0);
        run_op("t6_and", 3'd5, 1'b0, 4'h2, {16{8'hA5}}, {16{8'h3C}}, {16{8'h24}});
        run_op("t6_or",  3'd6, 1'b0, 4'h1, {16{8'hA5}}, {16{8'h3C}}, {16{8'hBD}});

        // Reset on the second busy cycle discards the op.
        op = 3'd0; bcast = 1'b0; wa_in = 4'h9; opa = rnd128(); opb = rnd128();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("t5.busy", busy, 0);
        check_val("t5.ready", in_ready, 1);
        check_val("t5.we", we_out, 0);
        check_val("t5.wd", wd_out, 0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check_val("t5.no_pulse", we_out, 0);
        end

        // Random ops against the model.
        for (int t = 0; t < 20; t++) begin
            f  = 3'($urandom);
            bc = ($urandom_range(0, 3) == 0);
            wa = 4'($urandom);
            a  = rnd128();
            b  = rnd128();
            run_op("rand", f, bc, wa, a, b, model(f, bc, a, b));
        end

        // in_valid held high with new operands every cycle. Only ops offered
        // while idle are accepted, and accepts are six cycles apart.
        @(posedge clk); #1;
        last_acc = -100;
        pulses   = 0;
        pend_wd  = '0;
        pend_wa  = '0;
        for (int c = 0; c < 40; c++) begin
            exp_ready = !(c >= last_acc && c < last_acc + 5);
            exp_we    = (c == last_acc + 4);
            check_val("t4.ready", in_ready, exp_ready);
            check_val("t4.we", we_out, exp_we);
            if (exp_we) begin
                pulses++;
                check_val("t4.wa", wa_out, pend_wa);
                check_val("t4.wd", wd_out, pend_wd);
            end
            f  = 3'($urandom);
            bc = $urandom_range(0, 1) == 1;
            wa = 4'($urandom);
            a  = rnd128();
            b  = rnd128();
            op = f; bcast = bc; wa_in = wa; opa = a; opb = b; in_valid = 1'b1;
            if (exp_ready) begin
                last_acc = c + 1;
                pend_wa  = wa;
                pend_wd  = model(f, bc, a, b);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("t4.pulses", pulses, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
